mem_responder: RTL and testbench

Memory-side responder for the multiplier core's processor. It answers the processor's memory interface: address, write data, separate data-memory and instruction-memory write strobes, and 8-bit instruction and data read returns. It holds the instruction RAM and data RAM, and runs a load state machine that fills instruction memory from a host byte stream before it releases the core. It sits between the processor's memory port and the top-level host/loader logic.

---
 rtl/mem_responder.sv | 75 +++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: IM/DM RAMs for the core; LOAD fills IM from host bytes (load_valid/data/last, load_ready), RUN serves addr/to_mem/dm_wr/im_wr with 1-cycle dm_out/im_out, core_en, addr_err
module mem_responder #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] to_mem,
  input  logic        dm_wr,
  input  logic        im_wr,
  output logic [7:0]  dm_out,
  output logic [7:0]  im_out,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_en,
  output logic        addr_err
);
  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);
  typedef enum logic {LOAD, RUN} state_t;
  state_t         state_q, state_d;
  logic [IAW-1:0] ptr_q, ptr_d;
  logic [7:0]     im_mem [IM_DEPTH];
  logic [7:0]     dm_mem [DM_DEPTH];
  logic [7:0]     im_out_q, im_out_d, dm_out_q, dm_out_d;
  logic           addr_err_q, addr_err_d;
  logic           accept, im_oor, dm_oor, im_we, dm_we;
  logic [IAW-1:0] im_wa;
  logic [7:0]     im_wd;
  logic           unused_hi;
  assign unused_hi = ^to_mem[15:8];
  assign im_oor = |(addr >> IAW);
  assign dm_oor = |(addr >> DAW);
  assign accept = load_valid & load_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      im_out_q   <= 8'h00;
      dm_out_q   <= 8'h00;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      im_out_q   <= im_out_d;
      dm_out_q   <= dm_out_d;
      addr_err_q <= addr_err_d;
    end
  end
  always_comb begin
    ptr_d   = accept ? ptr_q + 1'b1 : ptr_q;
    state_d = (accept && (load_last || &ptr_q)) ? RUN : state_q;
  end
  always_comb begin
    load_ready = state_q == LOAD;
    core_en    = state_q == RUN;
    im_out_d   = (core_en && !im_oor) ? im_mem[addr[IAW-1:0]] : 8'h00;
    dm_out_d   = (core_en && !dm_oor) ? dm_mem[addr[DAW-1:0]] : 8'h00;
    addr_err_d = core_en && (im_oor || dm_oor);
    im_we      = !rst && (accept || (core_en && im_wr && !im_oor));
    im_wa      = core_en ? addr[IAW-1:0] : ptr_q;
    im_wd      = core_en ? to_mem[7:0] : load_data;
    dm_we      = !rst && core_en && dm_wr && !dm_oor;
  end
  always_ff @(posedge clk) begin
    if (im_we) im_mem[im_wa] <= im_wd;
    if (dm_we) dm_mem[addr[DAW-1:0]] <= to_mem[7:0];
  end
  assign im_out   = im_out_q;
  assign dm_out   = dm_out_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against an array-based memory model
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst, dm_wr, im_wr, load_valid, load_last;
  logic        load_ready, core_en, addr_err;
  logic [15:0] addr, to_mem;
  logic [7:0]  dm_out, im_out, load_data;
  logic [7:0]  im_ref [256];
  logic [7:0]  dm_ref [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .to_mem(to_mem), .dm_wr(dm_wr), .im_wr(im_wr),
    .dm_out(dm_out), .im_out(im_out), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .core_en(core_en), .addr_err(addr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; dm_wr = 0; im_wr = 0; load_valid = 0; load_last = 0;
    load_data = 0; addr = 0; to_mem = 0;
    tick; tick;
    rst = 0;
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready: got %b exp 1", load_ready); end
    n_cmp++; if (core_en !== 1'b0) begin n_err++; $display("FAIL reset_core_en: got %b exp 0", core_en); end
    n_cmp++; if (dm_out !== 8'h00) begin n_err++; $display("FAIL reset_dm_out: got %h exp 00", dm_out); end
    n_cmp++; if (im_out !== 8'h00) begin n_err++; $display("FAIL reset_im_out: got %h exp 00", im_out); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b exp 0", addr_err); end
  endtask

  task automatic test_load;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = 8'hA0 + 8'(i); load_last = (i == 2);
      tick;
      im_ref[i] = 8'hA0 + 8'(i);
      n_cmp++; if (core_en !== (i == 2)) begin n_err++; $display("FAIL load_core_en[%0d]: got %b exp %b", i, core_en, i == 2); end
      n_cmp++; if (load_ready !== (i != 2)) begin n_err++; $display("FAIL load_ready[%0d]: got %b exp %b", i, load_ready, i != 2); end
    end
    load_valid = 0; load_last = 0;
    for (int i = 0; i < 3; i++) begin
      addr = 16'(i);
      tick;
      n_cmp++; if (im_out !== im_ref[i]) begin n_err++; $display("FAIL load_readback[%0d]: got %h exp %h", i, im_out, im_ref[i]); end
    end
  endtask

  task automatic test_dm_rw;
    addr = 16'h0010; dm_wr = 1; to_mem = 16'h1255;
    tick;
    to_mem = 16'hBEEF;
    tick;
    n_cmp++; if (dm_out !== 8'h55) begin n_err++; $display("FAIL dm_read_first: got %h exp 55", dm_out); end
    dm_wr = 0;
    tick;
    n_cmp++; if (dm_out !== 8'hEF) begin n_err++; $display("FAIL dm_write_read: got %h exp ef", dm_out); end
    dm_ref[16] = 8'hEF;
  endtask

  task automatic test_both_strobes;
    addr = 16'd5; dm_wr = 1; im_wr = 1; to_mem = 16'h003C;
    tick;
    dm_wr = 0; im_wr = 0;
    tick;
    n_cmp++; if (im_out !== 8'h3C) begin n_err++; $display("FAIL both_im: got %h exp 3c", im_out); end
    n_cmp++; if (dm_out !== 8'h3C) begin n_err++; $display("FAIL both_dm: got %h exp 3c", dm_out); end
    im_ref[5] = 8'h3C; dm_ref[5] = 8'h3C;
  endtask

  task automatic test_out_of_range;
    addr = 16'h0000; dm_wr = 1; to_mem = 16'h0011;
    tick;
    dm_ref[0] = 8'h11;
    addr = 16'h0100; to_mem = 16'h0099;
    tick;
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_addr_err: got %b exp 1", addr_err); end
    n_cmp++; if (dm_out !== 8'h00) begin n_err++; $display("FAIL oor_dm_out: got %h exp 00", dm_out); end
    n_cmp++; if (im_out !== 8'h00) begin n_err++; $display("FAIL oor_im_out: got %h exp 00", im_out); end
    dm_wr = 0; addr = 16'h0000;
    tick;
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pulse: got %b exp 0", addr_err); end
    n_cmp++; if (dm_out !== 8'h11) begin n_err++; $display("FAIL oor_no_alias: got %h exp 11", dm_out); end
    n_cmp++; if (im_out !== im_ref[0]) begin n_err++; $display("FAIL oor_im0: got %h exp %h", im_out, im_ref[0]); end
  endtask

  task automatic test_reset_mid_run;
    rst = 1;
    tick;
    rst = 0;
    n_cmp++; if (core_en !== 1'b0) begin n_err++; $display("FAIL rr_core_en: got %b exp 0", core_en); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rr_load_ready: got %b exp 1", load_ready); end
    n_cmp++; if (dm_out !== 8'h00 || im_out !== 8'h00) begin n_err++; $display("FAIL rr_outs_zero: got %h/%h exp 00/00", dm_out, im_out); end
    addr = 16'h0010; dm_wr = 1; im_wr = 1; to_mem = 16'h0012;
    tick;
    n_cmp++; if (core_en !== 1'b0) begin n_err++; $display("FAIL rr_core_en_idle: got %b exp 0", core_en); end
    load_valid = 1; load_data = 8'h77; load_last = 1;
    tick;
    im_ref[0] = 8'h77;
    load_valid = 0; load_last = 0; dm_wr = 0; im_wr = 0;
    n_cmp++; if (core_en !== 1'b1) begin n_err++; $display("FAIL rr_core_en_run: got %b exp 1", core_en); end
    addr = 16'd0;
    tick;
    n_cmp++; if (im_out !== 8'h77) begin n_err++; $display("FAIL rr_im0: got %h exp 77", im_out); end
    addr = 16'd1;
    tick;
    n_cmp++; if (im_out !== 8'hA1) begin n_err++; $display("FAIL rr_im1: got %h exp a1", im_out); end
    addr = 16'h0010;
    tick;
    n_cmp++; if (dm_out !== dm_ref[16]) begin n_err++; $display("FAIL rr_load_dm_ignored: got %h exp %h", dm_out, dm_ref[16]); end
  endtask

  task automatic test_random;
    logic [7:0] e_im, e_dm;
    logic       e_err;
    int         a;
    for (int i = 0; i < 16; i++) begin
      addr = 16'h20 + 16'(i); dm_wr = 1; im_wr = 1; to_mem = 16'($urandom);
      tick;
      im_ref[32 + i] = to_mem[7:0]; dm_ref[32 + i] = to_mem[7:0];
    end
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 65535)) : 32 + int'($urandom_range(0, 15));
      addr = 16'(a); dm_wr = 1'($urandom); im_wr = 1'($urandom); to_mem = 16'($urandom);
      e_im = (a < 256) ? im_ref[a] : 8'h00;
      e_dm = (a < 256) ? dm_ref[a] : 8'h00;
      e_err = a >= 256;
      tick;
      n_cmp++; if (im_out !== e_im) begin n_err++; $display("FAIL rand_im[%0d] addr %h: got %h exp %h", i, a, im_out, e_im); end
      n_cmp++; if (dm_out !== e_dm) begin n_err++; $display("FAIL rand_dm[%0d] addr %h: got %h exp %h", i, a, dm_out, e_dm); end
      n_cmp++; if (addr_err !== e_err) begin n_err++; $display("FAIL rand_err[%0d] addr %h: got %b exp %b", i, a, addr_err, e_err); end
      if (a < 256 && im_wr) im_ref[a] = to_mem[7:0];
      if (a < 256 && dm_wr) dm_ref[a] = to_mem[7:0];
    end
    dm_wr = 0; im_wr = 0;
  endtask

  task automatic test_full_load;
    int a;
    rst = 1;
    tick;
    rst = 0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 0;
        tick;
        n_cmp++; if (core_en !== 1'b0) begin n_err++; $display("FAIL full_gap_core_en[%0d]: got %b exp 0", i, core_en); end
      end
      load_valid = 1; load_last = 0; load_data = 8'($urandom);
      tick;
      im_ref[i] = load_data;
      n_cmp++; if (core_en !== (i == 255)) begin n_err++; $display("FAIL full_core_en[%0d]: got %b exp %b", i, core_en, i == 255); end
    end
    load_data = 8'hFF;
    tick;
    load_valid = 0;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 0 : (i == 1) ? 255 : int'($urandom_range(0, 255));
      addr = 16'(a);
      tick;
      n_cmp++; if (im_out !== im_ref[a]) begin n_err++; $display("FAIL full_read addr %h: got %h exp %h", a, im_out, im_ref[a]); end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_dm_rw;
    test_both_strobes;
    test_out_of_range;
    test_reset_mid_run;
    test_random;
    test_full_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
